insn_fetch: RTL and testbench
=============================

Name: insn_fetch

Overview:
- Front-end stage that feeds the CPU core from a byte-wide, single-port, synchronous-read program memory.
- Tracks the core's program_counter and fetches three bytes (op_code, arg1, arg2).
- Tracks the core's dataindex and fetches the 32-bit dataparams word from the data segment.
- Presents NOP on op_code while an instruction fetch is in flight, which stalls the core naturally.

Parameters:
- DATA_BASE, 16'h8000, byte address of data-segment entry 0.
- NOP_OP, 8'h00, opcode driven while no valid instruction is available.

Ports:
- clk  input  1  clock.
- rst  input  1  reset; synchronous, active-high.
- pc  input  16  program_counter from the core.
- dindex  input  16  dataindex from the core.
- mem_en  output  1  read strobe to program memory.
- mem_addr  output  16  byte address to program memory.
- mem_rdata  input  8  read data; valid exactly 1 cycle after mem_en && mem_addr.
- op_code  output  8  current opcode to the core.
- arg1  output  8  first opcode argument.
- arg2  output  8  second opcode argument.
- dataparams  output  32  data-segment word at dindex.
- insn_valid  output  1  op_code/arg1/arg2 correspond to the current pc.
- data_valid  output  1  dataparams corresponds to the current dindex.
- busy  output  1  a burst is in progress.

Behaviour:
- Reset values: op_code=NOP_OP, arg1=arg2=0, dataparams=0, insn_valid=0, data_valid=0, mem_en=0, mem_addr=0, busy=0, state=IDLE.
- Reset clears both "fetched-address" tags to invalid, so the first non-reset cycle starts an instruction fetch of pc.
- Pending conditions:
  - Instruction fetch is pending when the instruction tag is invalid or ipc_tag != pc.
  - Data fetch is pending when the data tag is invalid or dtag != dindex.
- States:
  - IDLE: if an instruction fetch is pending, go to IFETCH (priority); else if a data fetch is pending, go to DFETCH; else stay.
  - On entering a burst, latch base address: pc for IFETCH, DATA_BASE + {dindex[13:0],2'b00} for DFETCH.
  - Address arithmetic is mod 2^16; wrap from 16'hFFFF to 16'h0000 is legal.
  - IFETCH: beats 0..2 drive mem_en=1, mem_addr=base+beat. Captures happen on beats 1..3 into op, a1, a2. Beat 3 has mem_en=0. 4 cycles total, then go to IDLE.
  - DFETCH: beats 0..3 issue base+0..3. Captures on beats 1..4, big-endian: byte at base+0 goes to dataparams[31:24]. 5 cycles total, then go to IDLE.
  - busy=1 in IFETCH/DFETCH.
- Bursts are non-preemptive.
- IFETCH completion:
  - If pc still equals the latched address, update op_code/arg1/arg2, set ipc_tag=pc and insn_valid=1.
  - Otherwise discard the captured bytes and keep op_code=NOP_OP. The IDLE cycle then re-detects pending and refetches.
- DFETCH completion: same rule against dindex, updating dataparams, dtag and data_valid.
- Pc change:
  - Any cycle where pc != ipc_tag forces op_code=NOP_OP and insn_valid=0 combinationally from the registered tag compare.
  - arg1/arg2 hold their old values.
  - The core therefore never sees a stale opcode.
- dindex change:
  - data_valid drops the same cycle.
  - dataparams holds its old value until the new word lands.
  - op_code is not forced to NOP for a data fetch, so LDC stays visible while its constant loads.
- Simultaneous pending instruction and data fetch: IFETCH first, then DFETCH via IDLE. There is one IDLE cycle between bursts.
- Reset asserted mid-burst aborts immediately. All outputs return to reset values on the next edge, and in-flight mem_rdata is ignored.
- Latency from a pc change seen in IDLE to a valid opcode: 5 cycles (1 IDLE detect + 4 IFETCH). Best case for data: 6 cycles.

Decomposition:
- Shared package fetch_pkg holds:
  - the fetch_state_t enum (IDLE, IFETCH, DFETCH);
  - localparams IFETCH_BEATS=3 and DFETCH_BEATS=4;
  - NOP_OP default.
- Opcode values stay in opcodes.vh.
- One natural sub-module, byte_assembler, is a beat-indexed byte-to-word shift register (width parameter 24/32). It is shared by both bursts; a single-instance implementation is also acceptable.

Test Plan:
- Reset release with pc=0 and mem[0..2]=B8,00,05:
  - op_code=00 during fetch;
  - op_code=B8, arg1=00, arg2=05, insn_valid=1 on cycle 5 after rst falls;
  - mem_addr sequence 0,1,2.
- pc steps 0->3 after valid, mem[3..5]=12,07,00:
  - op_code=00 and insn_valid=0 the same cycle;
  - op_code=12, arg1=07 five cycles later.
- With op_code=12 held, dindex 0->7 and mem[8000+28..+31]=DE,AD,BE,EF:
  - mem_addr 801C..801F;
  - dataparams=DEADBEEF, data_valid=1;
  - op_code stays 12 throughout.
- pc changes 3->40 during IFETCH beat 1: the first burst result is discarded, op_code stays 00, and a second burst at 0x0040 completes.
- pc=FFFF: mem_addr sequence FFFF, 0000, 0001; bytes assemble correctly.
- rst pulsed during DFETCH beat 2: next cycle dataparams=0, data_valid=0, op_code=00, state=IDLE, mem_en=0.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state type and burst constants for the instruction/data fetch stage
package fetch_pkg;
  typedef enum logic [1:0] {IDLE, IFETCH, DFETCH} fetch_state_t;
  localparam int IFETCH_BEATS = 3;
  localparam int DFETCH_BEATS = 4;
  localparam logic [7:0] DEFAULT_NOP_OP = 8'h00;
endpackage

// File: rtl/insn_fetch_byte_assembler.sv
// byte_assembler: shifts bytes in first-byte-most-significant, building a big-endian word
module byte_assembler #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [7:0]   din,
  output logic [W-1:0] word_nxt
);
  logic [W-1:0] word;
  assign word_nxt = {word[W-9:0], din};
  always_ff @(posedge clk)
    if (rst) word <= '0;
    else if (en) word <= word_nxt;
endmodule

// File: rtl/insn_fetch.sv
// insn_fetch: fetches the 3-byte instruction at pc and the 32-bit data word at dindex from byte memory
module insn_fetch import fetch_pkg::*; #(
  parameter logic [15:0] DATA_BASE = 16'h8000,
  parameter logic [7:0]  NOP_OP    = DEFAULT_NOP_OP
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] pc,
  input  logic [15:0] dindex,
  output logic        mem_en,
  output logic [15:0] mem_addr,
  input  logic [7:0]  mem_rdata,
  output logic [7:0]  op_code,
  output logic [7:0]  arg1,
  output logic [7:0]  arg2,
  output logic [31:0] dataparams,
  output logic        insn_valid,
  output logic        data_valid,
  output logic        busy
);
  fetch_state_t state, state_nxt;
  logic [2:0]  beat;
  logic [15:0] req, base, ipc_tag, dtag;
  logic        ipc_ok, dtag_ok, last, cap;
  logic [7:0]  op_r;
  logic [31:0] word_nxt;
  assign insn_valid = ipc_ok && ipc_tag == pc;
  assign data_valid = dtag_ok && dtag == dindex;
  assign op_code    = insn_valid ? op_r : NOP_OP;
  assign busy       = state != IDLE;
  assign base       = state == DFETCH ? DATA_BASE + {req[13:0], 2'b00} : req;
  assign last       = busy && beat == (state == DFETCH ? 3'(DFETCH_BEATS) : 3'(IFETCH_BEATS));
  assign cap        = busy && beat != 3'd0;
  assign mem_en     = busy && !last;
  assign mem_addr   = busy ? base + 16'(beat) : 16'h0000;
  byte_assembler #(.W(32)) u_asm (
    .clk      (clk),
    .rst      (rst),
    .en       (cap),
    .din      (mem_rdata),
    .word_nxt (word_nxt)
  );
  always_comb
    state_nxt = state == IDLE ? (!insn_valid ? IFETCH : !data_valid ? DFETCH : IDLE)
              : last ? IDLE : state;
  // req holds the pc or dindex the burst was launched for; completion only commits if it still matches
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      beat       <= '0;
      req        <= '0;
      ipc_tag    <= '0;
      dtag       <= '0;
      ipc_ok     <= 1'b0;
      dtag_ok    <= 1'b0;
      op_r       <= NOP_OP;
      arg1       <= '0;
      arg2       <= '0;
      dataparams <= '0;
    end else begin
      state <= state_nxt;
      beat  <= busy && !last ? beat + 3'd1 : 3'd0;
      if (!busy) req <= !insn_valid ? pc : dindex;
      if (last && state == IFETCH && pc == req) begin
        {op_r, arg1, arg2} <= word_nxt[23:0];
        ipc_tag            <= pc;
        ipc_ok             <= 1'b1;
      end
      if (last && state == DFETCH && dindex == req) begin
        dataparams <= word_nxt;
        dtag       <= dindex;
        dtag_ok    <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_insn_fetch.sv
// tb_insn_fetch: directed, table-driven and randomized checks of insn_fetch against a byte-memory model
module tb_insn_fetch;
  localparam logic [15:0] DATA_BASE = 16'h8000;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] pc = '0;
  logic [15:0] dindex = '0;
  logic        mem_en;
  logic [15:0] mem_addr;
  logic [7:0]  mem_rdata = '0;
  logic [7:0]  op_code, arg1, arg2;
  logic [31:0] dataparams;
  logic        insn_valid, data_valid, busy;
  logic [7:0]  mem [0:65535];
  logic [15:0] addr_log [$];
  int          n_chk = 0;
  int          n_fail = 0;

  typedef struct {
    logic [15:0] pc;
    logic [15:0] di;
    logic [7:0]  op;
    logic [7:0]  a1;
    logic [7:0]  a2;
    logic [31:0] dp;
  } vec_t;
  vec_t vecs [6];

  insn_fetch #(.DATA_BASE(DATA_BASE), .NOP_OP(8'h00)) dut (
    .clk        (clk),
    .rst        (rst),
    .pc         (pc),
    .dindex     (dindex),
    .mem_en     (mem_en),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .op_code    (op_code),
    .arg1       (arg1),
    .arg2       (arg2),
    .dataparams (dataparams),
    .insn_valid (insn_valid),
    .data_valid (data_valid),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // synchronous-read memory; junk on idle cycles exposes mistimed captures
  always @(posedge clk) begin
    if (mem_en) begin
      mem_rdata <= mem[mem_addr];
      addr_log.push_back(mem_addr);
    end else begin
      mem_rdata <= 8'($urandom);
    end
  end

  function automatic logic [31:0] dword(input logic [15:0] d);
    logic [15:0] a;
    a = DATA_BASE + {d[13:0], 2'b00};
    return {mem[a], mem[16'(a + 16'd1)], mem[16'(a + 16'd2)], mem[16'(a + 16'd3)]};
  endfunction

  function automatic logic [23:0] ibytes(input logic [15:0] p);
    return {mem[p], mem[16'(p + 16'd1)], mem[16'(p + 16'd2)]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_op"}, 32'(op_code), 32'h0);
    chk({tag, "_a1"}, 32'(arg1), 32'h0);
    chk({tag, "_a2"}, 32'(arg2), 32'h0);
    chk({tag, "_dp"}, dataparams, 32'h0);
    chk({tag, "_iv"}, 32'(insn_valid), 32'h0);
    chk({tag, "_dv"}, 32'(data_valid), 32'h0);
    chk({tag, "_en"}, 32'(mem_en), 32'h0);
    chk({tag, "_addr"}, 32'(mem_addr), 32'h0);
    chk({tag, "_busy"}, 32'(busy), 32'h0);
  endtask

  task automatic chk_insn(input string tag, input logic [23:0] exp);
    chk({tag, "_iv"}, 32'(insn_valid), 32'h1);
    chk({tag, "_bytes"}, {8'h00, op_code, arg1, arg2}, {8'h00, exp});
  endtask

  task automatic chk_run(input string tag, input int off, input logic [15:0] start, input int n);
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_addr%0d", tag, off + i),
          off + i < addr_log.size() ? 32'(addr_log[off + i]) : 32'hFFFFFFFF,
          32'(16'(start + 16'(i))));
    end
  endtask

  task automatic wait_both(input string tag);
    int k;
    k = 0;
    #1;
    while (!(insn_valid && data_valid) && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_timeout"}, 32'(insn_valid && data_valid), 32'h1);
  endtask

  initial begin
    int si, sd;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    {mem[16'h0000], mem[16'h0001], mem[16'h0002]} = 24'hB80005;
    {mem[16'h0003], mem[16'h0004], mem[16'h0005], mem[16'h0006]} = 32'h1207005A;
    {mem[16'h0020], mem[16'h0021], mem[16'h0022]} = 24'hAABBCC;
    {mem[16'h0040], mem[16'h0041], mem[16'h0042]} = 24'h334455;
    mem[16'hFFFF] = 8'h9A;
    {mem[16'h8000], mem[16'h8001], mem[16'h8002], mem[16'h8003]} = 32'h0F1E2D3C;
    {mem[16'h800C], mem[16'h800D], mem[16'h800E], mem[16'h800F]} = 32'h11223344;
    {mem[16'h801C], mem[16'h801D], mem[16'h801E], mem[16'h801F]} = 32'hDEADBEEF;
    {mem[16'hC000], mem[16'hC001], mem[16'hC002], mem[16'hC003]} = 32'h01234567;
    {mem[16'h7FFC], mem[16'h7FFD], mem[16'h7FFE], mem[16'h7FFF]} = 32'hCAFEBABE;
    vecs[0] = '{16'h0000, 16'h0007, 8'hB8, 8'h00, 8'h05, 32'hDEADBEEF};
    vecs[1] = '{16'h0003, 16'h1000, 8'h12, 8'h07, 8'h00, 32'h01234567};
    vecs[2] = '{16'h0040, 16'h4007, 8'h33, 8'h44, 8'h55, 32'hDEADBEEF};
    vecs[3] = '{16'hFFFF, 16'h3FFF, 8'h9A, 8'hB8, 8'h00, 32'hCAFEBABE};
    vecs[4] = '{16'h0020, 16'h0003, 8'hAA, 8'hBB, 8'hCC, 32'h11223344};
    vecs[5] = '{16'h0004, 16'h0000, 8'h07, 8'h00, 8'h5A, 32'h0F1E2D3C};

    // reset release: first instruction lands 5 cycles later
    repeat (3) @(negedge clk);
    chk_reset("rst");
    addr_log.delete();
    rst = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk($sformatf("boot_nop%0d", k), 32'(op_code), 32'h0);
      chk($sformatf("boot_iv%0d", k), 32'(insn_valid), 32'h0);
    end
    @(negedge clk);
    chk_insn("boot", 24'hB80005);
    chk("boot_nlog", 32'(addr_log.size()), 32'd3);
    chk_run("boot", 0, 16'h0000, 3);
    wait_both("boot_data");
    chk("boot_dp", dataparams, 32'h0F1E2D3C);

    // pc step: NOP the same cycle, new opcode 5 cycles later
    pc = 16'h0003;
    #1;
    chk("pc3_nop", 32'(op_code), 32'h0);
    chk("pc3_iv", 32'(insn_valid), 32'h0);
    chk("pc3_a2_hold", 32'(arg2), 32'h05);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk($sformatf("pc3_nop%0d", k), 32'(op_code), 32'h0);
    end
    @(negedge clk);
    chk_insn("pc3", 24'h120700);

    // dindex change: opcode stays visible while the word loads
    addr_log.delete();
    dindex = 16'h0007;
    #1;
    chk("ldc_dv0", 32'(data_valid), 32'h0);
    chk("ldc_dp_hold", dataparams, 32'h0F1E2D3C);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk($sformatf("ldc_op%0d", k), 32'(op_code), 32'h12);
      chk($sformatf("ldc_dv%0d", k), 32'(data_valid), 32'h0);
    end
    @(negedge clk);
    chk("ldc_op6", 32'(op_code), 32'h12);
    chk("ldc_dv6", 32'(data_valid), 32'h1);
    chk("ldc_dp", dataparams, 32'hDEADBEEF);
    chk("ldc_nlog", 32'(addr_log.size()), 32'd4);
    chk_run("ldc", 0, 16'h801C, 4);

    // pc moves during IFETCH beat 1: first burst discarded, refetch at 0x0040
    addr_log.delete();
    pc = 16'h0020;
    repeat (2) @(negedge clk);
    chk("mid_busy", 32'(busy), 32'h1);
    pc = 16'h0040;
    for (int k = 3; k <= 9; k++) begin
      @(negedge clk);
      chk($sformatf("mid_nop%0d", k), 32'(op_code), 32'h0);
    end
    @(negedge clk);
    chk_insn("mid", 24'h334455);
    chk("mid_nlog", 32'(addr_log.size()), 32'd6);
    chk_run("mid_a", 0, 16'h0020, 3);
    chk_run("mid_b", 3, 16'h0040, 3);

    // address wrap at the top of memory
    addr_log.delete();
    pc = 16'hFFFF;
    repeat (5) @(negedge clk);
    chk_insn("wrap", 24'h9AB800);
    chk("wrap_nlog", 32'(addr_log.size()), 32'd3);
    chk_run("wrap", 0, 16'hFFFF, 3);

    // reset during DFETCH beat 2
    dindex = 16'h0003;
    repeat (3) @(negedge clk);
    chk("rstmid_busy", 32'(busy), 32'h1);
    rst = 1'b1;
    @(negedge clk);
    chk_reset("rstmid");
    rst = 1'b0;

    foreach (vecs[i]) begin
      pc = vecs[i].pc;
      dindex = vecs[i].di;
      wait_both($sformatf("vec%0d", i));
      chk_insn($sformatf("vec%0d", i), {vecs[i].op, vecs[i].a1, vecs[i].a2});
      chk($sformatf("vec%0d_dp", i), dataparams, vecs[i].dp);
    end

    // random pc/dindex traffic checked against the memory contents and latency bounds
    si = 0;
    sd = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      si++;
      sd++;
      if (insn_valid) chk("rnd_insn", {8'h00, op_code, arg1, arg2}, {8'h00, ibytes(pc)});
      else chk("rnd_nop", 32'(op_code), 32'h0);
      if (data_valid) chk("rnd_dp", dataparams, dword(dindex));
      if (si >= 12) chk("rnd_ilive", 32'(insn_valid), 32'h1);
      if (sd >= 24) chk("rnd_dlive", 32'(data_valid), 32'h1);
      if ($urandom_range(0, 31) == 0) begin
        pc = 16'($urandom);
        si = 0;
        sd = 0;
      end
      if ($urandom_range(0, 31) == 0) begin
        dindex = 16'($urandom);
        sd = 0;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
